// File: rtl/daq_stream_pkg.sv
// daq_stream_pkg
// Shared definitions for the DAQ event stream: framing markers, the event
// framing FSM state encoding and the default beat-count width. Imported by
// the event word source and by the 32->64-bit packer.
package daq_stream_pkg;

  localparam int NW_WIDTH_DEF = 12;

  localparam logic [7:0]  HDR_MARKER = 8'hA5;
  localparam logic [15:0] TRL_MARKER = 16'hE0E0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR0    = 3'd1,
    ST_HDR1    = 3'd2,
    ST_DATA    = 3'd3,
    ST_TRAILER = 3'd4
  } evt_state_e;

endpackage

// File: rtl/stream_skid2.sv
// stream_skid2
// Two-entry valid/ready buffer between the sample-buffer read return and the
// stream output. The writer has no ready; it must only push when a slot is
// free, which it decides from free_slots.
// Ports:
//   clk, rst             clock, async active-high reset
//   in_valid, in_data    write side (one word per cycle when in_valid)
//   out_valid, out_data  head of buffer
//   out_ready            consumer pops the head when out_valid && out_ready
//   free_slots           2 - occupancy
module stream_skid2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   free_slots
);

  logic [W-1:0] slot0;  // head
  logic [W-1:0] slot1;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  assign push       = in_valid;
  assign pop        = out_valid && out_ready;
  assign out_valid  = (count != 2'd0);
  assign out_data   = slot0;
  assign free_slots = 2'd2 - count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= in_data;
          else               slot1 <= in_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // pop needs a valid head, so count is 1 or 2 here
          if (count == 2'd1) begin
            slot0 <= in_data;
          end else begin
            slot0 <= slot1;
            slot1 <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/event_word_source.sv
// event_word_source
// Frames one DAQ event per accepted trigger as a 32-bit word stream:
// HDR0 {A5, event number}, HDR1 beat count, 2*nb data words read from the
// sample buffer, and a trailer {E0E0, word count} flagged with fifo_last.
// Ports:
//   clk, rst                   clock, async active-high reset
//   trigger, num_beats         event request and its length in 64-bit beats
//   mem_rd_en, mem_addr        sample-buffer read strobe / address
//   mem_rdata                  read data, one cycle after mem_rd_en
//   fifo_data/valid/ready/last output stream
//   busy                       FSM not idle
//   trig_dropped               saturating count of triggers ignored while busy
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | waiting for trigger
// ST_HDR0    | presenting {A5, evt}; sample prefetch starts here
// ST_HDR1    | presenting nb
// ST_DATA    | presenting buffered sample words
// ST_TRAILER | presenting {E0E0, 2*nb}, fifo_last=1
module event_word_source
  import daq_stream_pkg::*;
#(
  parameter int NW_WIDTH   = NW_WIDTH_DEF,
  parameter int ADDR_WIDTH = NW_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trigger,
  input  logic [NW_WIDTH-1:0]   num_beats,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_rdata,
  output logic [31:0]           fifo_data,
  output logic                  fifo_valid,
  input  logic                  fifo_ready,
  output logic                  fifo_last,
  output logic                  busy,
  output logic [15:0]           trig_dropped
);

  evt_state_e            state;
  logic [NW_WIDTH-1:0]   nb;
  logic [NW_WIDTH-1:0]   nb_in;
  logic [ADDR_WIDTH-1:0] words_in;
  logic [23:0]           evt;
  logic [23:0]           trig_num;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] rd_left;
  logic [ADDR_WIDTH-1:0] data_left;
  logic                  rd_pending;
  logic                  rd_issue;
  logic                  fire;
  logic                  pop_data;
  logic                  skid_valid;
  logic [31:0]           skid_data;
  logic [1:0]            free_slots;
  logic [2:0]            room;
  logic [31:0]           nb32;

  assign nb_in    = (num_beats == '0) ? NW_WIDTH'(1) : num_beats;
  assign words_in = ADDR_WIDTH'({nb_in, 1'b0});
  assign nb32     = {{(32-NW_WIDTH){1'b0}}, nb};

  assign fire     = fifo_valid && fifo_ready;
  assign pop_data = fire && (state == ST_DATA);

  // A read may issue only if its data, landing next cycle, is sure to find a
  // slot: the read already in flight takes one, a pop this cycle frees one.
  assign room     = {1'b0, free_slots} + {2'b00, pop_data};
  assign rd_issue = ((state == ST_HDR0) || (state == ST_HDR1) || (state == ST_DATA))
                    && (rd_left != '0) && (room > {2'b00, rd_pending});

  assign mem_rd_en = rd_issue;
  assign mem_addr  = rd_addr;
  assign busy      = (state != ST_IDLE);

  stream_skid2 #(.W(32)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (rd_pending),
    .in_data    (mem_rdata),
    .out_valid  (skid_valid),
    .out_data   (skid_data),
    .out_ready  (pop_data),
    .free_slots (free_slots)
  );

  always_comb begin
    fifo_valid = 1'b0;
    fifo_data  = '0;
    fifo_last  = 1'b0;
    case (state)
      ST_HDR0: begin
        fifo_valid = 1'b1;
        fifo_data  = {HDR_MARKER, evt};
      end
      ST_HDR1: begin
        fifo_valid = 1'b1;
        fifo_data  = nb32;
      end
      ST_DATA: begin
        fifo_valid = skid_valid;
        fifo_data  = skid_data;
      end
      ST_TRAILER: begin
        fifo_valid = 1'b1;
        fifo_data  = {TRL_MARKER, nb32[14:0], 1'b0};
        fifo_last  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      nb           <= '0;
      evt          <= '0;
      trig_num     <= '0;
      rd_addr      <= '0;
      rd_left      <= '0;
      data_left    <= '0;
      rd_pending   <= 1'b0;
      trig_dropped <= '0;
    end else begin
      rd_pending <= rd_issue;
      if (rd_issue) begin
        rd_addr <= rd_addr + ADDR_WIDTH'(1);
        rd_left <= rd_left - ADDR_WIDTH'(1);
      end

      if (trigger && (state != ST_IDLE) && (trig_dropped != 16'hFFFF))
        trig_dropped <= trig_dropped + 16'd1;

      case (state)
        ST_IDLE: begin
          if (trigger) begin
            nb        <= nb_in;
            evt       <= trig_num;
            trig_num  <= trig_num + 24'd1;
            rd_addr   <= '0;
            rd_left   <= words_in;
            data_left <= words_in;
            state     <= ST_HDR0;
          end
        end
        ST_HDR0: if (fire) state <= ST_HDR1;
        ST_HDR1: if (fire) state <= ST_DATA;
        ST_DATA: begin
          if (fire) begin
            data_left <= data_left - ADDR_WIDTH'(1);
            if (data_left == ADDR_WIDTH'(1)) state <= ST_TRAILER;
          end
        end
        ST_TRAILER: begin
          if (fire) begin
            state   <= ST_IDLE;
            rd_addr <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
